// File: rtl/uart_port_master_pkg.sv
// Shared constants for the UART-to-port-bus bridge: command/response bytes and FSM encodings.
package uart_port_master_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h2E;
  localparam logic [7:0] RSP_ERR = 8'h3F;

  localparam logic [2:0] ST_GET_CMD  = 3'd0;
  localparam logic [2:0] ST_GET_ADDR = 3'd1;
  localparam logic [2:0] ST_GET_DATA = 3'd2;
  localparam logic [2:0] ST_WR_STB   = 3'd3;
  localparam logic [2:0] ST_RD_STB   = 3'd4;
  localparam logic [2:0] ST_SEND     = 3'd5;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_WR) || (b == CMD_RD);
  endfunction

endpackage

// File: rtl/uart_port_master_timeout.sv
// Inter-byte idle counter for the bridge; only present when UPM_TIMEOUT_EN is defined.
`ifdef UPM_TIMEOUT_EN
module uart_port_master_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_expired;

  // Counts run cycles since the last clear; expiry latches until cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_expired <= 1'b0;
    end else if (clr) begin
      r_cnt     <= '0;
      r_expired <= 1'b0;
    end else if (run && !r_expired) begin
      r_cnt     <= r_cnt + CNT_W'(1);
      r_expired <= (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    end
  end

  assign expired = r_expired;

endmodule
`endif

// File: rtl/uart_port_master.sv
// UART-to-port-bus initiator: parses 'W' addr data / 'R' addr from the rx FIFO, strobes the port bus,
// and returns one response byte. UPM_TIMEOUT_EN adds an inter-byte abort timer.
module uart_port_master
  import uart_port_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_empty,
  input  logic [7:0] rx_data,
  output logic       rd_uart,
  input  logic       tx_full,
  output logic       wr_uart,
  output logic [7:0] w_data,
  output logic [7:0] port_id,
  output logic [7:0] out_port,
  output logic       write_strobe,
  output logic       read_strobe,
  input  logic [7:0] in_port,
  output logic       busy
);

  logic [2:0] r_state;
  logic [2:0] w_next_state;
  logic [7:0] r_cmd;
  logic [7:0] r_port_id;
  logic [7:0] r_out_port;
  logic [7:0] r_resp;
  logic       r_write_strobe;
  logic       r_read_strobe;
  logic       r_busy;
  logic       w_pop;
  logic       w_push;
  logic       w_timeout;

`ifdef UPM_TIMEOUT_EN
  logic w_waiting;
  assign w_waiting = (r_state == ST_GET_ADDR) || (r_state == ST_GET_DATA);

  uart_port_master_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clr    (w_pop || !w_waiting),
    .run    (w_waiting && rx_empty),
    .expired(w_timeout)
  );
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = |32'(TIMEOUT_CYCLES);
  assign w_timeout = 1'b0;
`endif

  // Next-state and pop/push decode; a waiting byte wins over a simultaneous timeout.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_push       = 1'b0;
    case (r_state)
      ST_GET_CMD: begin
        if (!rx_empty) begin
          w_pop        = 1'b1;
          w_next_state = is_cmd(rx_data) ? ST_GET_ADDR : ST_SEND;
        end
      end
      ST_GET_ADDR: begin
        if (!rx_empty) begin
          w_pop        = 1'b1;
          w_next_state = (r_cmd == CMD_WR) ? ST_GET_DATA : ST_RD_STB;
        end else if (w_timeout) begin
          w_next_state = ST_SEND;
        end
      end
      ST_GET_DATA: begin
        if (!rx_empty) begin
          w_pop        = 1'b1;
          w_next_state = ST_WR_STB;
        end else if (w_timeout) begin
          w_next_state = ST_SEND;
        end
      end
      ST_WR_STB: w_next_state = ST_SEND;
      ST_RD_STB: w_next_state = ST_SEND;
      ST_SEND: begin
        if (!tx_full) begin
          w_push       = 1'b1;
          w_next_state = ST_GET_CMD;
        end
      end
      default: w_next_state = ST_GET_CMD;
    endcase
  end

  // State, captured command fields, response and registered strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_GET_CMD;
      r_cmd          <= 8'h00;
      r_port_id      <= 8'h00;
      r_out_port     <= 8'h00;
      r_resp         <= 8'h00;
      r_write_strobe <= 1'b0;
      r_read_strobe  <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_write_strobe <= (w_next_state == ST_WR_STB);
      r_read_strobe  <= (w_next_state == ST_RD_STB);
      r_busy         <= (w_next_state != ST_GET_CMD);
      case (r_state)
        ST_GET_CMD: begin
          if (w_pop) begin
            r_cmd <= rx_data;
            if (!is_cmd(rx_data)) r_resp <= RSP_ERR;
          end
        end
        ST_GET_ADDR: begin
          if (w_pop)          r_port_id <= rx_data;
          else if (w_timeout) r_resp    <= RSP_ERR;
        end
        ST_GET_DATA: begin
          if (w_pop)          r_out_port <= rx_data;
          else if (w_timeout) r_resp     <= RSP_ERR;
        end
        ST_WR_STB: r_resp <= RSP_ACK;
        ST_RD_STB: r_resp <= in_port;
        default: ;
      endcase
    end
  end

  assign rd_uart      = w_pop;
  assign wr_uart      = w_push;
  assign w_data       = r_resp;
  assign port_id      = r_port_id;
  assign out_port     = r_out_port;
  assign write_strobe = r_write_strobe;
  assign read_strobe  = r_read_strobe;
  assign busy         = r_busy;

endmodule

// File: tb/tb_uart_port_master.sv
// Scoreboard bench for uart_port_master: directed commands, expected strobes/tx bytes queued, monitor compares.
module tb_uart_port_master;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } stb_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_empty = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rd_uart;
  logic       tx_full = 1'b0;
  logic       wr_uart;
  logic [7:0] w_data;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] in_port;
  logic       busy;

  logic [7:0] port_mem [256];
  logic [7:0] rx_q [$];
  logic [7:0] exp_tx [$];
  stb_t       exp_stb [$];

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int wr_cnt = 0;
  int stb_cnt = 0;

  uart_port_master #(.TIMEOUT_CYCLES(100)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_empty    (rx_empty),
    .rx_data     (rx_data),
    .rd_uart     (rd_uart),
    .tx_full     (tx_full),
    .wr_uart     (wr_uart),
    .w_data      (w_data),
    .port_id     (port_id),
    .out_port    (out_port),
    .write_strobe(write_strobe),
    .read_strobe (read_strobe),
    .in_port     (in_port),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  assign in_port = port_mem[port_id];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // rx FIFO model: pop on rd_uart at the edge, present head byte at the falling edge.
  always @(posedge clk) begin
    if (rd_uart && rx_q.size() > 0) begin
      void'(rx_q.pop_front());
      pops++;
    end
  end

  always @(negedge clk) begin
    rx_empty = (rx_q.size() == 0);
    rx_data  = rx_empty ? 8'h00 : rx_q[0];
  end

  // Monitor: compare every strobe and every tx push against the scoreboard queues.
  always @(negedge clk) begin
    if (reset) begin
      if (write_strobe && read_strobe) check("strobe_exclusive", 32'd1, 32'd0);
      if (write_strobe || read_strobe) begin
        stb_t e;
        stb_cnt++;
        if (exp_stb.size() == 0) begin
          check("unexpected_strobe", {23'd0, write_strobe, port_id}, 32'h0);
        end else begin
          e = exp_stb.pop_front();
          check("strobe_we", {31'd0, write_strobe}, {31'd0, e.we});
          check("strobe_port_id", {24'd0, port_id}, {24'd0, e.addr});
          if (e.we) check("strobe_out_port", {24'd0, out_port}, {24'd0, e.data});
        end
      end
      if (wr_uart) begin
        wr_cnt++;
        if (exp_tx.size() == 0) check("unexpected_tx", {24'd0, w_data}, 32'h100);
        else check("tx_byte", {24'd0, w_data}, {24'd0, exp_tx.pop_front()});
      end
    end
  end

  task automatic push_bytes(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int n);
    if (n > 0) rx_q.push_back(b0);
    if (n > 1) rx_q.push_back(b1);
    if (n > 2) rx_q.push_back(b2);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (!(rx_q.size() == 0 && exp_tx.size() == 0 && exp_stb.size() == 0 && !busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, {31'd0, n >= 2000}, 32'd0);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_strobes"}, {30'd0, write_strobe, read_strobe}, 32'd0);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_port_id"}, {24'd0, port_id}, 32'd0);
    check({name, "_out_port"}, {24'd0, out_port}, 32'd0);
    check({name, "_uart"}, {30'd0, rd_uart, wr_uart}, 32'd0);
    check({name, "_w_data"}, {24'd0, w_data}, 32'd0);
  endtask

  initial begin
    int p0;
    int s0;
    int n;
    for (int i = 0; i < 256; i++) port_mem[i] = 8'h00;
    port_mem[1] = 8'h3C;
    port_mem[2] = 8'h77;
    port_mem[3] = 8'h99;

    #23;
    check_outputs_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    // Write command
    exp_stb.push_back('{we: 1'b1, addr: 8'h03, data: 8'hA5});
    exp_tx.push_back(8'h2E);
    p0 = pops;
    push_bytes(8'h57, 8'h03, 8'hA5, 3);
    wait_idle("write");
    check("write_pops", pops - p0, 32'd3);
    check("write_port_id_held", {24'd0, port_id}, 32'h03);
    check("write_out_port_held", {24'd0, out_port}, 32'hA5);

    // Read command
    exp_stb.push_back('{we: 1'b0, addr: 8'h01, data: 8'h00});
    exp_tx.push_back(8'h3C);
    p0 = pops;
    push_bytes(8'h52, 8'h01, 8'h00, 2);
    wait_idle("read");
    check("read_pops", pops - p0, 32'd2);

    // Bad command then a normal read
    s0 = stb_cnt;
    exp_tx.push_back(8'h3F);
    push_bytes(8'h41, 8'h00, 8'h00, 1);
    wait_idle("badcmd");
    check("badcmd_no_strobe", stb_cnt - s0, 32'd0);
    exp_stb.push_back('{we: 1'b0, addr: 8'h02, data: 8'h00});
    exp_tx.push_back(8'h77);
    push_bytes(8'h52, 8'h02, 8'h00, 2);
    wait_idle("read_after_bad");

    // Back-pressure on the tx FIFO
    tx_full = 1'b1;
    s0 = wr_cnt;
    exp_stb.push_back('{we: 1'b1, addr: 8'h04, data: 8'h5A});
    exp_tx.push_back(8'h2E);
    push_bytes(8'h57, 8'h04, 8'h5A, 3);
    n = 0;
    while (exp_stb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("bp_strobe_seen", {31'd0, n >= 200}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_wr_uart_low", {31'd0, wr_uart}, 32'd0);
      check("bp_busy_high", {31'd0, busy}, 32'd1);
    end
    tx_full = 1'b0;
    wait_idle("bp");
    check("bp_single_push", wr_cnt - s0, 32'd1);

`ifdef UPM_TIMEOUT_EN
    // Inter-byte timeout aborts with an error response
    s0 = stb_cnt;
    exp_tx.push_back(8'h3F);
    push_bytes(8'h57, 8'h00, 8'h00, 1);
    repeat (60) @(negedge clk);
    check("to_not_early", {31'd0, busy}, 32'd1);
    wait_idle("timeout");
    check("to_no_strobe", stb_cnt - s0, 32'd0);
`else
    // Long gap between bytes is tolerated
    push_bytes(8'h57, 8'h00, 8'h00, 1);
    repeat (1000) @(negedge clk);
    check("gap_still_busy", {31'd0, busy}, 32'd1);
    exp_stb.push_back('{we: 1'b1, addr: 8'h05, data: 8'h10});
    exp_tx.push_back(8'h2E);
    push_bytes(8'h05, 8'h10, 8'h00, 2);
    wait_idle("gap");
`endif

    // Reset in the middle of a command
    s0 = stb_cnt;
    p0 = pops;
    push_bytes(8'h57, 8'h03, 8'h00, 2);
    n = 0;
    while (pops - p0 < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_partial_popped", pops - p0, 32'd2);
    #2 reset = 1'b0;
    #1 check_outputs_zero("midreset");
    @(negedge clk);
    reset = 1'b1;
    check("rst_no_strobe", stb_cnt - s0, 32'd0);
    exp_stb.push_back('{we: 1'b0, addr: 8'h03, data: 8'h00});
    exp_tx.push_back(8'h99);
    push_bytes(8'h52, 8'h03, 8'h00, 2);
    wait_idle("read_after_reset");

    check("leftover_tx", exp_tx.size(), 32'd0);
    check("leftover_stb", exp_stb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
